// File: rtl/brcomp_pkg.sv
// Shared types, default parameters and helpers for the iterative branch comparator.
package brcomp_pkg;

    // Default operand width and per-cycle slice width.
    localparam int unsigned XlenDefault  = 32;
    localparam int unsigned ChunkDefault = 8;

    typedef enum logic [1:0] {
        StIdle,
        StCmp,
        StDone
    } brcomp_state_e;

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so the datapath only ever needs an unsigned compare.
    function automatic logic sign_bias_msb(input logic msb, input logic is_signed);
        return msb ^ is_signed;
    endfunction

endpackage

// File: rtl/brcomp_chunk.sv
// Combinational unsigned compare of one CHUNK-wide slice.
module brcomp_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    output logic             lt_o,
    output logic             eq_o
);

    // Pure compare; no state.
    always_comb begin
        lt_o = (a_i < b_i);
        eq_o = (a_i == b_i);
    end

endmodule

// File: rtl/brcomp_iter.sv
// Multi-cycle MSB-first branch comparator with valid/ready on both sides.
// Optional build macro BRCOMP_ITER_EARLY_EXIT_EN: stop on the first differing
// chunk; otherwise every compare takes all NCHUNK cycles (constant time).
module brcomp_iter
    import brcomp_pkg::*;
#(
    parameter int unsigned XLEN  = XlenDefault,
    parameter int unsigned CHUNK = ChunkDefault
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            br_unsign_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic            br_less_o,
    output logic            br_equal_o,
    output logic            busy_o
);

    localparam int unsigned NCHUNK = XLEN / CHUNK;
    localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NCHUNK - 1);

    if ((XLEN % CHUNK) != 0) begin : g_bad_chunk
        $fatal(1, "brcomp_iter: CHUNK must divide XLEN");
    end

    brcomp_state_e   state_q, state_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            less_q, less_d;
    logic            equal_q, equal_d;
`ifndef BRCOMP_ITER_EARLY_EXIT_EN
    // Set once the first differing chunk has been captured.
    logic            found_q, found_d;
`endif

    logic chunk_lt;
    logic chunk_eq;

    // Operands are shifted left after each equal chunk, so the current chunk
    // (index idx_q) always sits in the top CHUNK bits.
    brcomp_chunk #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .a_i (a_q[XLEN-1 -: CHUNK]),
        .b_i (b_q[XLEN-1 -: CHUNK]),
        .lt_o(chunk_lt),
        .eq_o(chunk_eq)
    );

    // Next-state and handshake outputs.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        less_d  = less_q;
        equal_d = equal_q;
`ifndef BRCOMP_ITER_EARLY_EXIT_EN
        found_d = found_q;
`endif
        ready_o = (state_q == StIdle);
        valid_o = (state_q == StDone);
        busy_o  = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (valid_i) begin
                    a_d     = {sign_bias_msb(rs1_data_i[XLEN-1], ~br_unsign_i),
                               rs1_data_i[XLEN-2:0]};
                    b_d     = {sign_bias_msb(rs2_data_i[XLEN-1], ~br_unsign_i),
                               rs2_data_i[XLEN-2:0]};
                    idx_d   = '0;
                    less_d  = 1'b0;
                    equal_d = 1'b0;
`ifndef BRCOMP_ITER_EARLY_EXIT_EN
                    found_d = 1'b0;
`endif
                    state_d = StCmp;
                end
            end
            StCmp: begin
`ifdef BRCOMP_ITER_EARLY_EXIT_EN
                if (!chunk_eq) begin
                    less_d  = chunk_lt;
                    equal_d = 1'b0;
                    state_d = StDone;
                end else if (idx_q == LastIdx) begin
                    less_d  = 1'b0;
                    equal_d = 1'b1;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                    a_d   = a_q << CHUNK;
                    b_d   = b_q << CHUNK;
                end
`else
                // Only the first difference is kept; later chunks are ignored.
                if (!found_q && !chunk_eq) begin
                    less_d  = chunk_lt;
                    found_d = 1'b1;
                end
                if (idx_q == LastIdx) begin
                    equal_d = !found_q && chunk_eq;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                    a_d   = a_q << CHUNK;
                    b_d   = b_q << CHUNK;
                end
`endif
            end
            StDone: begin
                if (ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Results are only driven while the handshake presents them.
    always_comb begin
        br_less_o  = (state_q == StDone) && less_q;
        br_equal_o = (state_q == StDone) && equal_q;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            less_q  <= 1'b0;
            equal_q <= 1'b0;
`ifndef BRCOMP_ITER_EARLY_EXIT_EN
            found_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            less_q  <= less_d;
            equal_q <= equal_d;
`ifndef BRCOMP_ITER_EARLY_EXIT_EN
            found_q <= found_d;
`endif
        end
    end

endmodule

// File: tb/tb_brcomp_iter.sv
// Directed self-checking bench for brcomp_iter (XLEN=32, CHUNK=8).
// Honours BRCOMP_ITER_EARLY_EXIT_EN for the expected latencies.
module tb_brcomp_iter;

`ifdef BRCOMP_ITER_EARLY_EXIT_EN
    localparam bit EarlyEn = 1'b1;
`else
    localparam bit EarlyEn = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        br_unsign_i;
    logic        valid_o;
    logic        ready_i;
    logic        br_less_o;
    logic        br_equal_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    brcomp_iter #(
        .XLEN (32),
        .CHUNK(8)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .br_unsign_i(br_unsign_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .br_less_o  (br_less_o),
        .br_equal_o (br_equal_o),
        .busy_o     (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Expected latency: j+1 edges with early exit, NCHUNK (4) edges otherwise.
    function automatic int exp_lat(input int j);
        return EarlyEn ? (j + 1) : 4;
    endfunction

    // Waits for valid_o after the accept edge; returns edges counted (20 = timeout).
    task automatic wait_valid(output int n);
        n = 0;
        while (!valid_o && n < 20) begin
            tick();
            n++;
        end
    endtask

    // One full transaction from IDLE, ready_i held high.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic uns, input logic el, input logic ee, input int lat);
        int n;
        rs1_data_i  = a;
        rs2_data_i  = b;
        br_unsign_i = uns;
        valid_i     = 1'b1;
        ready_i     = 1'b1;
        check({tag, "_ready"}, 32'(ready_o), 32'd1);
        tick();
        valid_i = 1'b0;
        wait_valid(n);
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_less"}, 32'(br_less_o), 32'(el));
        check({tag, "_equal"}, 32'(br_equal_o), 32'(ee));
        tick();
        check({tag, "_idle"}, 32'(ready_o), 32'd1);
    endtask

    initial begin
        int n;
        rst_i       = 1'b1;
        valid_i     = 1'b0;
        ready_i     = 1'b1;
        rs1_data_i  = '0;
        rs2_data_i  = '0;
        br_unsign_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_less", 32'(br_less_o), 32'd0);
        check("rst_equal", 32'(br_equal_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);

        // Basic vectors: j is the first differing byte index from the MSB.
        run_op("u_5_7", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b0, 4);
        run_op("s_m1_1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0, exp_lat(0));
        run_op("u_m1_1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, exp_lat(0));
        run_op("s_eq80", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 4);
        run_op("u_eq80", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 4);
        run_op("s_5_7", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0, 4);
        run_op("u_j1", 32'h1234_5678, 32'h1236_5678, 1'b1, 1'b1, 1'b0, exp_lat(1));
        run_op("u_j2gt", 32'h1234_9978, 32'h1234_5678, 1'b1, 1'b0, 1'b0, exp_lat(2));
        run_op("u_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, exp_lat(0));
        run_op("s_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, exp_lat(0));

        // Output backpressure: results held, new requests ignored.
        rs1_data_i  = 32'hFFFF_FFFF;
        rs2_data_i  = 32'h0000_0001;
        br_unsign_i = 1'b0;
        valid_i     = 1'b1;
        ready_i     = 1'b0;
        tick();
        rs1_data_i  = 32'h0000_0009;
        rs2_data_i  = 32'h0000_0002;
        br_unsign_i = 1'b1;
        wait_valid(n);
        check("bp_lat", 32'(n), 32'(exp_lat(0)));
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_valid", 32'(valid_o), 32'd1);
            check("bp_less", 32'(br_less_o), 32'd1);
            check("bp_equal", 32'(br_equal_o), 32'd0);
            check("bp_ready", 32'(ready_o), 32'd0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        check("bp_rel_ready", 32'(ready_o), 32'd1);
        check("bp_rel_valid", 32'(valid_o), 32'd0);

        // Reset one cycle into CMP.
        rs1_data_i  = 32'h0000_0005;
        rs2_data_i  = 32'h0000_0007;
        br_unsign_i = 1'b1;
        valid_i     = 1'b1;
        tick();
        valid_i = 1'b0;
        check("mid_busy", 32'(busy_o), 32'd1);
        check("mid_valid0", 32'(valid_o), 32'd0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid_ready", 32'(ready_o), 32'd1);
        check("mid_valid1", 32'(valid_o), 32'd0);
        check("mid_busy0", 32'(busy_o), 32'd0);
        check("mid_less", 32'(br_less_o), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("mid_valid_idle", 32'(valid_o), 32'd0);
        end
        run_op("post_rst", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b0, 4);

        // Back-to-back with both handshakes held high; one idle cycle between.
        ready_i = 1'b1;
        valid_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                rs1_data_i  = 32'hFFFF_FFFF;
                rs2_data_i  = 32'h0000_0001;
                br_unsign_i = 1'b0;
            end else begin
                rs1_data_i  = 32'h1234_5678;
                rs2_data_i  = 32'h1234_5678;
                br_unsign_i = 1'b1;
            end
            tick();
            check("b2b_accept", 32'(busy_o), 32'd1);
            wait_valid(n);
            check("b2b_lat", 32'(n), 32'((k % 2 == 0) ? exp_lat(0) : 4));
            check("b2b_less", 32'(br_less_o), 32'((k % 2 == 0) ? 1 : 0));
            check("b2b_equal", 32'(br_equal_o), 32'((k % 2 == 0) ? 0 : 1));
            if (k == 5) valid_i = 1'b0;
            tick();
            check("b2b_bubble", 32'(ready_o), 32'd1);
            check("b2b_bubble_v", 32'(valid_o), 32'd0);
        end
        tick();
        check("end_idle", 32'(busy_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
